// File: rtl/conv_window_generator.sv
// conv_window_generator: raster pixel stream to KxK valid-only windows, stride 1; `define WINDOW_POS_EN adds win_row/win_col
module conv_window_generator #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   image,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic                                            out_last,
  output logic                                            frame_done
`ifdef WINDOW_POS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0]                   win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                    win_col
`endif
);
  localparam int K  = KERNEL_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K-1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K-1);
  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] lb [K-1][IMG_WIDTH];
  logic [DW-1:0] win [K][K];
  logic [DW-1:0] win_nxt [K][K];
  logic [K*K*DW-1:0] flat;
  logic acc, emit, eol, eof;
  assign acc  = in_valid && in_ready;
  assign eol  = col == COL_LAST;
  assign eof  = eol && row == ROW_LAST;
  assign emit = acc && row >= ROW_FIRST && col >= COL_FIRST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FILL;
    else state <= state_nxt;
  always_comb
    state_nxt = state == FILL ? (acc && row == ROW_FIRST ? RUN : FILL) :
                state == RUN  ? (acc && eof ? DONE : RUN) :
                                (out_valid && out_ready ? FILL : DONE);
  always_comb begin
    in_ready   = state != DONE && !(out_valid && !out_ready);
    frame_done = state == DONE && out_valid && out_ready;
  end
  // new rightmost column: buffered rows oldest-first, live pixel at the bottom
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++) win_nxt[r][c] = win[r][c+1];
    for (int r = 0; r < K-1; r++) win_nxt[r][K-1] = lb[r][col];
    win_nxt[K-1][K-1] = in_data;
    for (int i = 0; i < K*K; i++) flat[i*DW +: DW] = win_nxt[i/K][i%K];
  end
  always_ff @(posedge clk)
    if (acc) begin
      win <= win_nxt;
      for (int r = 0; r < K-2; r++) lb[r][col] <= lb[r+1][col];
      lb[K-2][col] <= in_data;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      image     <= '0;
    end else begin
      if (acc) begin
        col <= eol ? '0 : col + 1'b1;
        if (eol) row <= eof ? '0 : row + 1'b1;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= eof;
        image     <= flat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
`ifdef WINDOW_POS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      win_row <= '0;
      win_col <= '0;
    end else if (emit) begin
      win_row <= row - ROW_FIRST;
      win_col <= col - COL_FIRST;
    end
`endif
endmodule

// File: tb/tb_conv_window_generator.sv
// tb_conv_window_generator: directed and randomized frames checked against a window-enumeration reference model
module tb_conv_window_generator;
  localparam int DW = 32;
  localparam int K = 3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int IW = K*K*DW;
  localparam int NPIX = W*H;
  localparam int FIRST_PIX = (K-1)*W + K-1;
  typedef struct {
    logic [IW-1:0] img;
    logic last;
    int r;
    int c;
  } win_t;
  logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [DW-1:0] in_data;
  logic [IW-1:0] image;
`ifdef WINDOW_POS_EN
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;
`endif
  int n_assert = 0;
  int n_fail = 0;
  int rmode = 0;
  bit busy = 0;
  win_t exp_q[$];
  logic [DW-1:0] frm [NPIX];
  int first_idx[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  conv_window_generator #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .image(image), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done)
`ifdef WINDOW_POS_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : 1'($urandom_range(1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] win_img(input logic [DW-1:0] px [NPIX], input int r, input int c);
    logic [IW-1:0] v = '0;
    for (int i = 0; i < K*K; i++) v[i*DW +: DW] = px[(r + i/K)*W + c + i%K];
    return v;
  endfunction

  function automatic logic [IW-1:0] pack(input int base);
    logic [IW-1:0] v = '0;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(base + first_idx[i]);
    return v;
  endfunction

  function automatic void enqueue(input logic [DW-1:0] px [NPIX]);
    for (int r = 0; r <= H-K; r++)
      for (int c = 0; c <= W-K; c++) begin
        win_t e;
        e.img = win_img(px, r, c);
        e.last = r == H-K && c == W-K;
        e.r = r;
        e.c = c;
        exp_q.push_back(e);
      end
  endfunction

  always @(negedge clk)
    if (reset) begin
      if (out_valid && out_ready) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected window: observed %0h expected none", image);
        end
        if (exp_q.size() != 0) begin
          check("window image", image, exp_q[0].img);
          check_bit("window out_last", out_last, exp_q[0].last);
          check_bit("frame_done on handshake", frame_done, exp_q[0].last);
`ifdef WINDOW_POS_EN
          check("win_row", IW'(win_row), IW'(exp_q[0].r));
          check("win_col", IW'(win_col), IW'(exp_q[0].c));
`endif
          void'(exp_q.pop_front());
        end
      end else check_bit("frame_done idle", frame_done, 1'b0);
    end

  task automatic push(input logic [DW-1:0] d, input bit gaps);
    int t = 0;
    bit ok = 0;
    while (gaps && $urandom_range(1) == 1) begin
      in_valid = 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_data = d;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 0;
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL push timeout: in_ready observed 0 for pixel %0h, expected 1", d);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] px [NPIX], input bit gaps, input logic [IW-1:0] exp_first);
    enqueue(px);
    for (int i = 0; i < NPIX; i++) begin
      push(px[i], gaps);
      if (i == FIRST_PIX) begin
        check_bit("first window out_valid", out_valid, 1'b1);
        check("first window image", image, exp_first);
      end else if (i < FIRST_PIX) check_bit("fill out_valid", out_valid, 1'b0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: %0d windows outstanding, expected 0", exp_q.size());
    end
    check_bit("idle out_valid", out_valid, 1'b0);
    check_bit("idle in_ready", in_ready, 1'b1);
  endtask

  task automatic seq_frame(input int base);
    for (int i = 0; i < NPIX; i++) frm[i] = DW'(base + i);
  endtask

  initial begin
    int t;
    reset = 0;
    in_valid = 0;
    in_data = '0;
    #3;
    check("reset image", image, '0);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset out_last", out_last, 1'b0);
    check_bit("reset frame_done", frame_done, 1'b0);
    check_bit("reset in_ready", in_ready, 1'b1);
`ifdef WINDOW_POS_EN
    check("reset win_row", IW'(win_row), '0);
    check("reset win_col", IW'(win_col), '0);
`endif
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    // single frame at full throughput
    seq_frame(0);
    send_frame(frm, 0, pack(0));
    drain();
    // stall with the first window pending
    rmode = 1;
    repeat (2) @(posedge clk);
    #1;
    seq_frame(0);
    busy = 1;
    fork
      begin
        send_frame(frm, 0, pack(0));
        busy = 0;
      end
    join_none
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_bit("stall window appears", out_valid, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall image held", image, pack(0));
      check_bit("stall out_valid held", out_valid, 1'b1);
      check_bit("stall in_ready", in_ready, 1'b0);
    end
    rmode = 0;
    t = 0;
    while (busy && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_bit("stall sender finished", busy, 1'b0);
    drain();
    // two frames back to back
    seq_frame(0);
    send_frame(frm, 0, pack(0));
    seq_frame(100);
    send_frame(frm, 0, pack(100));
    drain();
    // reset with a window pending mid-frame
    rmode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= FIRST_PIX; i++) push(DW'(i), 0);
    check_bit("pre-reset out_valid", out_valid, 1'b1);
    #2;
    reset = 0;
    #1;
    check_bit("async reset out_valid", out_valid, 1'b0);
    check_bit("async reset out_last", out_last, 1'b0);
    check("async reset image", image, '0);
    @(negedge clk);
    reset = 1;
    rmode = 0;
    @(posedge clk);
    #1;
    seq_frame(16);
    send_frame(frm, 0, pack(16));
    drain();
    // randomized gaps on both sides
    rmode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) frm[i] = $urandom;
      send_frame(frm, 1, win_img(frm, 0, 0));
    end
    drain();
    rmode = 0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
